ram_word_serial_ctrl: RTL

//  Upstream controller for the bit-wide RAM built from 1x1 RAM cells.

---
 rtl/ram_word_serial_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram_word_serial_ctrl.sv
// Word-to-bit serialising controller for a bit-wide RAM built from 1x1 cells.
// A word request is split into WORD_W single-bit accesses, LSB first; read bits
// are reassembled into rsp_rdata and each request ends with a one-cycle rsp_valid.
module ram_word_serial_ctrl #(
    parameter int unsigned WORD_W  = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned WADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wr,
    input  logic [WADDR_W-1:0]       req_addr,
    input  logic [WORD_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [WORD_W-1:0]        rsp_rdata,
    output logic                     busy,
    output logic [WADDR_W+IDX_W-1:0] ram_addr,
    output logic                     ram_rw,
    output logic                     ram_din,
    input  logic                     ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 wr_q, wr_d;
    logic [WADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]    wdata_q, wdata_d;
    logic [WORD_W-1:0]    rdata_q, rdata_d;
    logic                 accept;
    logic                 last_bit;

    assign accept   = req_valid && (state_q == S_IDLE);
    assign last_bit = (idx_q == IDX_W'(WORD_W - 1));

    // State and datapath registers; clear abandons any transfer in flight
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic; unknown encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = req_wr ? S_WRITE : S_READ;
            S_WRITE: if (last_bit) state_d = S_DONE;
            S_READ:  if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: request latch, bit index walk, read-bit capture
    always_comb begin
        idx_d   = idx_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    idx_d   = '0;
                end
            end
            S_WRITE: begin
                idx_d = last_bit ? '0 : idx_q + IDX_W'(1);
            end
            S_READ: begin
                rdata_d[idx_q] = ram_dout;
                idx_d          = last_bit ? '0 : idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from the registered state; ram_rw only ever asserts in WRITE
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        ram_addr  = '0;
        ram_rw    = 1'b0;
        ram_din   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_WRITE: begin
                ram_addr = {addr_q, idx_q};
                ram_rw   = wr_q;
                ram_din  = wdata_q[idx_q];
            end
            S_READ: begin
                ram_addr = {addr_q, idx_q};
            end
            S_DONE: begin
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp_rdata = rdata_q;

endmodule
